// File: rtl/gray_step_tracker.sv
// Receive side of a gray-coded count bus: decodes each valid sample, classifies it
// as hold / legal step / illegal jump, and tracks a signed position and error count.
module gray_step_tracker #(
    parameter int N     = 3,
    parameter int POS_W = 8,
    parameter int ERR_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [N-1:0]     gray_i,
    input  logic             clr_i,
    output logic [N-1:0]     bin_o,
    output logic             locked_o,
    output logic             step_o,
    output logic             dir_o,
    output logic             wrap_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [POS_W-1:0] pos_o
);

    typedef enum logic {
        ACQ,
        TRACK
    } state_t;

    localparam logic [N-1:0]     BIN_MAX = '1;
    localparam logic [N-1:0]     BIN_ZERO = '0;
    localparam logic [N-1:0]     DIFF_UP = N'(1);
    localparam logic [N-1:0]     DIFF_DOWN = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    state_t         state;
    logic [N-1:0]   decoded;
    logic [N-1:0]   diff;
    logic           acc;

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        acc     = 1'b0;
        decoded = '0;
        for (int i = N - 1; i >= 0; i--) begin
            acc        = acc ^ gray_i[i];
            decoded[i] = acc;
        end
    end

    assign diff = decoded - bin_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ACQ;
            bin_o     <= '0;
            locked_o  <= 1'b0;
            step_o    <= 1'b0;
            dir_o     <= 1'b0;
            wrap_o    <= 1'b0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
            pos_o     <= '0;
        end else begin
            step_o <= 1'b0;
            wrap_o <= 1'b0;
            err_o  <= 1'b0;
            // Clear wins over a same-cycle sample; the reference value is kept.
            if (clr_i) begin
                state     <= ACQ;
                locked_o  <= 1'b0;
                err_cnt_o <= '0;
                pos_o     <= '0;
            end else if (valid_i) begin
                case (state)
                    ACQ: begin
                        bin_o    <= decoded;
                        locked_o <= 1'b1;
                        state    <= TRACK;
                    end
                    TRACK: begin
                        if (diff == DIFF_UP) begin
                            step_o <= 1'b1;
                            dir_o  <= 1'b0;
                            wrap_o <= (bin_o == BIN_MAX);
                            pos_o  <= pos_o + POS_ONE;
                            bin_o  <= decoded;
                        end else if (diff == DIFF_DOWN) begin
                            step_o <= 1'b1;
                            dir_o  <= 1'b1;
                            wrap_o <= (bin_o == BIN_ZERO);
                            pos_o  <= pos_o - POS_ONE;
                            bin_o  <= decoded;
                        end else if (diff != '0) begin
                            // Illegal jump: re-reference so the next sample is judged from here.
                            err_o <= 1'b1;
                            bin_o <= decoded;
                            if (err_cnt_o != ERR_MAX) begin
                                err_cnt_o <= err_cnt_o + ERR_W'(1);
                            end
                        end
                    end
                    default: state <= ACQ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_step_tracker.sv
// Self-checking bench for gray_step_tracker: integer-level reference model compared
// every cycle, plus hand-computed literal checks for each scenario.
module tb_gray_step_tracker;

    logic       clk_i;
    logic       rst_ni;
    logic       valid_i;
    logic [2:0] gray_i;
    logic       clr_i;
    logic [2:0] bin_o;
    logic       locked_o;
    logic       step_o;
    logic       dir_o;
    logic       wrap_o;
    logic       err_o;
    logic [3:0] err_cnt_o;
    logic [7:0] pos_o;

    int testsRun = 0;
    int testsFailed = 0;
    bit checkEn = 0;

    // Reference model state, kept as plain integers.
    int  mLocked, mBin, mPos, mErrCnt, mDir, mStep, mWrap, mErr;

    gray_step_tracker #(.N(3), .POS_W(8), .ERR_W(4)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .gray_i    (gray_i),
        .clr_i     (clr_i),
        .bin_o     (bin_o),
        .locked_o  (locked_o),
        .step_o    (step_o),
        .dir_o     (dir_o),
        .wrap_o    (wrap_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o),
        .pos_o     (pos_o)
    );

    initial begin
        clk_i = 0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic int grayToBin(input int g);
        int b = 0;
        for (int s = g; s != 0; s = s >> 1) b = b ^ s;
        return b;
    endfunction

    function automatic logic [2:0] binToGray(input int b);
        int g;
        g = b ^ (b >> 1);
        return g[2:0];
    endfunction

    task automatic resetModel();
        mLocked = 0; mBin = 0; mPos = 0; mErrCnt = 0;
        mDir = 0; mStep = 0; mWrap = 0; mErr = 0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the model advances on the same edge as the DUT.
    task automatic applyStimulus(input bit v, input logic [2:0] g, input bit c);
        int d, nb;
        @(negedge clk_i);
        valid_i = v;
        gray_i  = g;
        clr_i   = c;
        @(posedge clk_i);
        mStep = 0; mWrap = 0; mErr = 0;
        if (!rst_ni) begin
            resetModel();
        end else if (c) begin
            mPos = 0; mErrCnt = 0; mLocked = 0;
        end else if (v) begin
            nb = grayToBin(int'(g));
            if (!mLocked) begin
                mBin = nb;
                mLocked = 1;
            end else begin
                d = (nb - mBin + 8) % 8;
                if (d == 1) begin
                    mStep = 1; mDir = 0; mWrap = (mBin == 7);
                    mPos = (mPos + 1) % 256; mBin = nb;
                end else if (d == 7) begin
                    mStep = 1; mDir = 1; mWrap = (mBin == 0);
                    mPos = (mPos + 255) % 256; mBin = nb;
                end else if (d != 0) begin
                    mErr = 1; mBin = nb;
                    if (mErrCnt < 15) mErrCnt++;
                end
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (checkEn) begin
            checkOutput("bin", 32'(bin_o), 32'(mBin));
            checkOutput("locked", 32'(locked_o), 32'(mLocked));
            checkOutput("step", 32'(step_o), 32'(mStep));
            checkOutput("dir", 32'(dir_o), 32'(mDir));
            checkOutput("wrap", 32'(wrap_o), 32'(mWrap));
            checkOutput("err", 32'(err_o), 32'(mErr));
            checkOutput("err_cnt", 32'(err_cnt_o), 32'(mErrCnt));
            checkOutput("pos", 32'(pos_o), 32'(mPos));
        end
    end

    initial begin
        int b;
        rst_ni = 0; valid_i = 0; gray_i = 0; clr_i = 0;
        resetModel();
        applyStimulus(0, 3'b000, 0);
        applyStimulus(0, 3'b000, 0);
        #2;
        checkOutput("reset_pos", 32'(pos_o), 32'h0);
        checkOutput("reset_locked", 32'(locked_o), 32'h0);
        rst_ni = 1;
        checkEn = 1;

        // Acquire then three up steps, with a hold and an idle cycle mixed in.
        applyStimulus(1, 3'b000, 0);
        #2 checkOutput("acq_locked", 32'(locked_o), 32'h1);
        checkOutput("acq_step", 32'(step_o), 32'h0);
        applyStimulus(1, 3'b001, 0);
        applyStimulus(0, 3'b111, 0);
        applyStimulus(1, 3'b011, 0);
        applyStimulus(1, 3'b010, 0);
        #2 checkOutput("t1_pos", 32'(pos_o), 32'd3);
        checkOutput("t1_bin", 32'(bin_o), 32'd3);
        applyStimulus(1, 3'b010, 0);
        #2 checkOutput("hold_step", 32'(step_o), 32'h0);

        // Up through 7 -> 0 wraps, then back down 0 -> 7 wraps.
        applyStimulus(1, 3'b110, 0);
        applyStimulus(1, 3'b111, 0);
        applyStimulus(1, 3'b101, 0);
        applyStimulus(1, 3'b100, 0);
        applyStimulus(1, 3'b000, 0);
        #2 checkOutput("wrap_up", 32'(wrap_o), 32'h1);
        checkOutput("wrap_up_pos", 32'(pos_o), 32'd8);
        applyStimulus(1, 3'b100, 0);
        #2 checkOutput("wrap_dn_dir", 32'(dir_o), 32'h1);
        checkOutput("wrap_dn_pos", 32'(pos_o), 32'd7);

        // Illegal jump 1 -> 4 re-references, then 4 -> 5 is a legal step.
        applyStimulus(1, 3'b000, 0);
        applyStimulus(1, 3'b001, 0);
        applyStimulus(1, 3'b110, 0);
        #2 checkOutput("jump_err", 32'(err_o), 32'h1);
        checkOutput("jump_cnt", 32'(err_cnt_o), 32'd1);
        checkOutput("jump_pos", 32'(pos_o), 32'd9);
        checkOutput("jump_bin", 32'(bin_o), 32'd4);
        applyStimulus(1, 3'b111, 0);
        #2 checkOutput("after_jump_step", 32'(step_o), 32'h1);
        checkOutput("after_jump_pos", 32'(pos_o), 32'd10);

        // Twenty jumps of +4 saturate the error counter.
        b = 5;
        for (int i = 0; i < 20; i++) begin
            b = (b + 4) % 8;
            applyStimulus(1, binToGray(b), 0);
        end
        #2 checkOutput("sat_cnt", 32'(err_cnt_o), 32'd15);
        checkOutput("sat_err", 32'(err_o), 32'h1);

        // Clear with a same-cycle sample; the sample is dropped.
        applyStimulus(1, 3'b110, 1);
        #2 checkOutput("clr_pos", 32'(pos_o), 32'd0);
        checkOutput("clr_locked", 32'(locked_o), 32'h0);
        checkOutput("clr_bin", 32'(bin_o), 32'd5);
        applyStimulus(1, 3'b000, 0);
        #2 checkOutput("reacq_step", 32'(step_o), 32'h0);
        checkOutput("reacq_bin", 32'(bin_o), 32'd0);

        // 130 up steps: position wraps 127 -> -128.
        b = 0;
        for (int i = 1; i <= 130; i++) begin
            b = (b + 1) % 8;
            applyStimulus(1, binToGray(b), 0);
            if (i == 128) begin
                #2 checkOutput("pos_wrap", 32'(pos_o), 32'h80);
            end
        end
        #2 checkOutput("pos_after", 32'(pos_o), 32'h82);

        // Asynchronous reset between edges clears outputs immediately.
        rst_ni = 0;
        #1;
        checkOutput("async_pos", 32'(pos_o), 32'h0);
        checkOutput("async_bin", 32'(bin_o), 32'h0);
        checkOutput("async_locked", 32'(locked_o), 32'h0);
        resetModel();
        applyStimulus(0, 3'b000, 0);
        #2 rst_ni = 1;
        applyStimulus(1, 3'b011, 0);
        #2 checkOutput("rst_reacq_bin", 32'(bin_o), 32'd2);
        checkOutput("rst_reacq_step", 32'(step_o), 32'h0);
        applyStimulus(1, 3'b010, 0);
        #2 checkOutput("rst_step_pos", 32'(pos_o), 32'd1);
        applyStimulus(0, 3'b000, 0);

        checkEn = 0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
